// File: rtl/ultrasonido_controlador.sv
`default_nettype none
// ============================================================================
// Module      : ultrasonido_controlador
// Description : Ultrasonic range-finder controller. Issues a trigger pulse,
//               times the echo pulse through a two-flop synchronizer, and
//               reports the distance in centimetres (one count per 58 us of
//               echo) or a timeout when no complete echo is seen.
//               Optional macro ULTRASONIDO_AUTO_EN adds a HOLD state that
//               re-triggers automatically after HOLDOFF_US.
// Revision    : 1.0 - initial release
// ============================================================================
module ultrasonido_controlador #(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int TRIG_US     = 10,
    parameter int TIMEOUT_US  = 38000,
    parameter int DIST_W      = 9,
    parameter int HOLDOFF_US  = 60000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              echo,
    output logic              trigger,
    output logic              busy,
    output logic [DIST_W-1:0] dist_cm,
    output logic              valid,
    output logic              timeout
);

    // ------------------------------------------------------------------------
    // Derived cycle counts and counter widths
    // ------------------------------------------------------------------------
    localparam int TRIG_CYC    = CLK_FREQ_HZ / 1000000 * TRIG_US;
    localparam int CM_CYC      = CLK_FREQ_HZ / 1000000 * 58;
    localparam int TIMEOUT_CYC = CLK_FREQ_HZ / 1000000 * TIMEOUT_US;
    localparam int HOLDOFF_CYC = CLK_FREQ_HZ / 1000000 * HOLDOFF_US;

    localparam int TRIG_W = (TRIG_CYC > 1)    ? $clog2(TRIG_CYC)    : 1;
    localparam int CM_W   = (CM_CYC > 1)      ? $clog2(CM_CYC)      : 1;
    localparam int TO_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
`ifdef ULTRASONIDO_AUTO_EN
    localparam int HOLD_W = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;
`endif

    // Reject parameter sets that collapse a phase to zero cycles.
    generate
        if (TRIG_CYC < 1 || CM_CYC < 2 || TIMEOUT_CYC < 2 || HOLDOFF_CYC < 1) begin : g_param_check
            $error("ultrasonido_controlador: derived cycle counts too small");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TRIG      = 3'd1,
        S_WAIT_RISE = 3'd2,
        S_MEASURE   = 3'd3,
        S_DONE      = 3'd4
`ifdef ULTRASONIDO_AUTO_EN
        ,
        S_HOLD      = 3'd5
`endif
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_echo_meta;
    logic              r_echo_s;

    logic [TRIG_W-1:0] r_trig_cnt;
    logic [TRIG_W-1:0] w_trig_cnt_nxt;
    logic [TO_W-1:0]   r_to_cnt;
    logic [TO_W-1:0]   w_to_cnt_nxt;
    logic [CM_W-1:0]   r_cm_cnt;
    logic [CM_W-1:0]   w_cm_cnt_nxt;
    logic [DIST_W-1:0] r_acc;
    logic [DIST_W-1:0] w_acc_nxt;
    logic              r_seen_low;
    logic              w_seen_low_nxt;
`ifdef ULTRASONIDO_AUTO_EN
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [HOLD_W-1:0] w_hold_cnt_nxt;
    logic              w_hold_hit;
`endif

    logic              w_trig_hit;
    logic              w_to_hit;
    logic              w_cm_hit;
    logic              w_acc_full;
    logic              w_done_good;
    logic              w_done_to;

    logic              r_trigger;
    logic              r_busy;
    logic [DIST_W-1:0] r_dist;
    logic              r_valid;
    logic              r_timeout;

    assign w_trig_hit = (r_trig_cnt == TRIG_W'(TRIG_CYC - 1));
    assign w_to_hit   = (r_to_cnt   == TO_W'(TIMEOUT_CYC - 1));
    assign w_cm_hit   = (r_cm_cnt   == CM_W'(CM_CYC - 1));
    assign w_acc_full = &r_acc;
`ifdef ULTRASONIDO_AUTO_EN
    assign w_hold_hit = (r_hold_cnt == HOLD_W'(HOLDOFF_CYC - 1));
`endif

    // Two-flop synchronizer for the asynchronous echo line
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_echo_meta <= 1'b0;
            r_echo_s    <= 1'b0;
        end else begin
            r_echo_meta <= echo;
            r_echo_s    <= r_echo_meta;
        end
    end

    // Next-state, counter updates and DONE outcome decode
    always_comb begin
        w_state_nxt    = r_state;
        w_trig_cnt_nxt = r_trig_cnt;
        w_to_cnt_nxt   = r_to_cnt;
        w_cm_cnt_nxt   = r_cm_cnt;
        w_acc_nxt      = r_acc;
        w_seen_low_nxt = r_seen_low;
        w_done_good    = 1'b0;
        w_done_to      = 1'b0;
`ifdef ULTRASONIDO_AUTO_EN
        w_hold_cnt_nxt = r_hold_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt    = S_TRIG;
                    w_trig_cnt_nxt = '0;
                end
            end
            S_TRIG: begin
                if (w_trig_hit) begin
                    // Timeout window and stale-echo tracking start afresh here.
                    w_state_nxt    = S_WAIT_RISE;
                    w_trig_cnt_nxt = '0;
                    w_to_cnt_nxt   = '0;
                    w_seen_low_nxt = 1'b0;
                end else begin
                    w_trig_cnt_nxt = r_trig_cnt + TRIG_W'(1);
                end
            end
            S_WAIT_RISE: begin
                if (w_to_hit) begin
                    w_state_nxt = S_DONE;
                    w_done_to   = 1'b1;
                end else if (r_echo_s && r_seen_low) begin
                    // Only a rise after a low sample counts; an echo already
                    // high when we got here is a leftover from a prior ping.
                    w_state_nxt  = S_MEASURE;
                    w_cm_cnt_nxt = '0;
                    w_acc_nxt    = '0;
                    w_to_cnt_nxt = r_to_cnt + TO_W'(1);
                end else begin
                    w_to_cnt_nxt = r_to_cnt + TO_W'(1);
                    if (!r_echo_s) begin
                        w_seen_low_nxt = 1'b1;
                    end
                end
            end
            S_MEASURE: begin
                // The falling-edge cycle is also counted, which makes the
                // measured width equal to the echo width (rise is seen one
                // cycle late, fall likewise).
                if (w_cm_hit) begin
                    w_cm_cnt_nxt = '0;
                    if (!w_acc_full) begin
                        w_acc_nxt = r_acc + DIST_W'(1);
                    end
                end else begin
                    w_cm_cnt_nxt = r_cm_cnt + CM_W'(1);
                end
                if (!r_echo_s) begin
                    // Echo fall wins over a coincident timeout.
                    w_state_nxt = S_DONE;
                    w_done_good = 1'b1;
                end else if (w_to_hit) begin
                    w_state_nxt = S_DONE;
                    w_done_to   = 1'b1;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + TO_W'(1);
                end
            end
            S_DONE: begin
`ifdef ULTRASONIDO_AUTO_EN
                w_state_nxt    = S_HOLD;
                w_hold_cnt_nxt = '0;
`else
                w_state_nxt    = S_IDLE;
`endif
            end
`ifdef ULTRASONIDO_AUTO_EN
            S_HOLD: begin
                if (w_hold_hit) begin
                    w_state_nxt    = S_TRIG;
                    w_trig_cnt_nxt = '0;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + HOLD_W'(1);
                end
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_trig_cnt <= '0;
            r_to_cnt   <= '0;
            r_cm_cnt   <= '0;
            r_acc      <= '0;
            r_seen_low <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_trig_cnt <= w_trig_cnt_nxt;
            r_to_cnt   <= w_to_cnt_nxt;
            r_cm_cnt   <= w_cm_cnt_nxt;
            r_acc      <= w_acc_nxt;
            r_seen_low <= w_seen_low_nxt;
        end
    end

`ifdef ULTRASONIDO_AUTO_EN
    // Hold-off counter between automatic measurements
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold_cnt <= '0;
        end else begin
            r_hold_cnt <= w_hold_cnt_nxt;
        end
    end
`endif

    // Registered outputs, timed so they line up with the state they describe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_trigger <= 1'b0;
            r_busy    <= 1'b0;
            r_dist    <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_trigger <= (w_state_nxt == S_TRIG);
            r_busy    <= (w_state_nxt != S_IDLE);
            r_valid   <= w_done_good;
            r_timeout <= w_done_to;
            if (w_done_good) begin
                r_dist <= w_acc_nxt;
            end else if (w_done_to) begin
                r_dist <= '1;
            end
        end
    end

    assign trigger = r_trigger;
    assign busy    = r_busy;
    assign dist_cm = r_dist;
    assign valid   = r_valid;
    assign timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_ultrasonido_controlador.sv
`default_nettype none
// ============================================================================
// Module      : tb_ultrasonido_controlador
// Description : Directed self-checking bench for ultrasonido_controlador.
//               DUT A: 1 MHz clock, 9-bit distance, 1000 us timeout.
//               DUT B: 1 MHz clock, 4-bit distance, 2000 us timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ultrasonido_controlador;

`ifdef ULTRASONIDO_AUTO_EN
    localparam logic C_BUSY_AFTER_DONE = 1'b1;
`else
    localparam logic C_BUSY_AFTER_DONE = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       reset = 1'b1;

    logic       a_start = 1'b0;
    logic       a_echo  = 1'b0;
    logic       a_trigger, a_busy, a_valid, a_timeout;
    logic [8:0] a_dist;

    logic       b_start = 1'b0;
    logic       b_echo  = 1'b0;
    logic       b_trigger, b_busy, b_valid, b_timeout;
    logic [3:0] b_dist;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ultrasonido_controlador #(
        .CLK_FREQ_HZ(1000000), .TRIG_US(10), .TIMEOUT_US(1000),
        .DIST_W(9), .HOLDOFF_US(100)
    ) u_dut_a (
        .clk(clk), .reset(reset), .start(a_start), .echo(a_echo),
        .trigger(a_trigger), .busy(a_busy), .dist_cm(a_dist),
        .valid(a_valid), .timeout(a_timeout)
    );

    ultrasonido_controlador #(
        .CLK_FREQ_HZ(1000000), .TRIG_US(10), .TIMEOUT_US(2000),
        .DIST_W(4), .HOLDOFF_US(100)
    ) u_dut_b (
        .clk(clk), .reset(reset), .start(b_start), .echo(b_echo),
        .trigger(b_trigger), .busy(b_busy), .dist_cm(b_dist),
        .valid(b_valid), .timeout(b_timeout)
    );

    // ---------------- stimulus helpers (no checking inside) ----------------
    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1; a_start = 1'b0; a_echo = 1'b0; b_start = 1'b0; b_echo = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Pulse start on A and return at the first negedge with trigger low again.
    task automatic launch_a(output logic ok);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (!a_trigger) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic launch_b(output logic ok);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (!b_trigger) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    // ------------------------------- tests ---------------------------------
    task automatic test_reset;
        @(negedge clk);
        n_vec++; if (a_trigger !== 1'b0) begin n_err++; $display("FAIL reset_trigger: got %b expected 0", a_trigger); end
        n_vec++; if (a_busy !== 1'b0)    begin n_err++; $display("FAIL reset_busy: got %b expected 0", a_busy); end
        n_vec++; if (a_dist !== 9'd0)    begin n_err++; $display("FAIL reset_dist: got %0d expected 0", a_dist); end
        n_vec++; if (a_valid !== 1'b0)   begin n_err++; $display("FAIL reset_valid: got %b expected 0", a_valid); end
        n_vec++; if (a_timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b expected 0", a_timeout); end
        n_vec++; if ({b_trigger, b_busy, b_valid, b_timeout, b_dist} !== 8'd0)
            begin n_err++; $display("FAIL reset_dut_b: got %b expected 00000000", {b_trigger, b_busy, b_valid, b_timeout, b_dist}); end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL idle_without_start: busy got %b expected 0", a_busy); end
    endtask

    task automatic test_trigger;
        int  hi;
        logic seen;
        do_reset;
        n_vec++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL busy_before_start: got %b expected 0", a_busy); end
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        n_vec++; if (a_busy !== 1'b1)    begin n_err++; $display("FAIL busy_next_cycle: got %b expected 1", a_busy); end
        n_vec++; if (a_trigger !== 1'b1) begin n_err++; $display("FAIL trigger_next_cycle: got %b expected 1", a_trigger); end
        hi = 0;
        for (int i = 0; i < 50; i++) begin
            if (!a_trigger) break;
            hi++;
            @(negedge clk);
        end
        n_vec++; if (hi !== 10) begin n_err++; $display("FAIL trigger_width: got %0d cycles expected 10", hi); end
        n_vec++; if (a_busy !== 1'b1) begin n_err++; $display("FAIL busy_wait_rise: got %b expected 1", a_busy); end
        // start while waiting for echo must not re-trigger
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            if (a_trigger) seen = 1'b1;
            @(negedge clk);
        end
        n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL start_ignored_busy: trigger seen %b expected 0", seen); end
    endtask

    task automatic test_measure_10;
        logic ok;
        int   lat;
        logic found;
        do_reset;
        launch_a(ok);
        n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL m10_trigger_fall: got %b expected 1", ok); end
        a_echo = 1'b1;
        repeat (580) @(negedge clk);
        a_echo = 1'b0;
        n_vec++; if ({a_busy, a_valid} !== 2'b10) begin n_err++; $display("FAIL m10_busy_during: got %b expected 10", {a_busy, a_valid}); end
        lat = 0; found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (a_valid) begin found = 1'b1; break; end
        end
        // 2 synchronizer cycles plus one cycle to act on the fall
        n_vec++; if (!found || lat !== 3) begin n_err++; $display("FAIL m10_valid_latency: got found=%b lat=%0d expected lat=3", found, lat); end
        n_vec++; if (a_dist !== 9'd10)   begin n_err++; $display("FAIL m10_dist: got %0d expected 10", a_dist); end
        n_vec++; if (a_timeout !== 1'b0) begin n_err++; $display("FAIL m10_no_timeout: got %b expected 0", a_timeout); end
        @(negedge clk);
        n_vec++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL m10_valid_one_cycle: got %b expected 0", a_valid); end
        n_vec++; if (a_busy !== C_BUSY_AFTER_DONE) begin n_err++; $display("FAIL m10_busy_after_done: got %b expected %b", a_busy, C_BUSY_AFTER_DONE); end
        n_vec++; if (a_dist !== 9'd10) begin n_err++; $display("FAIL m10_dist_stable: got %0d expected 10", a_dist); end
    endtask

    task automatic test_cm_boundary;
        int   hi_tab [4] = '{57, 58, 115, 116};
        int   exp_tab[4] = '{0, 1, 1, 2};
        logic ok;
        logic found;
        for (int k = 0; k < 4; k++) begin
            do_reset;
            launch_a(ok);
            a_echo = 1'b1;
            repeat (hi_tab[k]) @(negedge clk);
            a_echo = 1'b0;
            found = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (a_valid) begin found = 1'b1; break; end
            end
            n_vec++;
            if (!ok || !found || a_dist !== 9'(exp_tab[k])) begin
                n_err++;
                $display("FAIL cm_boundary_%0d: got found=%b dist=%0d expected dist=%0d", hi_tab[k], found, a_dist, exp_tab[k]);
            end
        end
    endtask

    task automatic test_timeout;
        logic ok;
        int   n;
        logic vseen;
        logic tseen;
        do_reset;
        launch_a(ok);
        n = 0; vseen = 1'b0; tseen = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            n++;
            if (a_valid) vseen = 1'b1;
            if (a_timeout) begin tseen = 1'b1; break; end
        end
        n_vec++; if (!ok || !tseen || n !== 1000) begin n_err++; $display("FAIL to_latency: got seen=%b cycles=%0d expected 1000", tseen, n); end
        n_vec++; if (a_dist !== 9'd511) begin n_err++; $display("FAIL to_dist: got %0d expected 511", a_dist); end
        n_vec++; if (vseen || a_valid) begin n_err++; $display("FAIL to_no_valid: got %b expected 0", vseen | a_valid); end
        @(negedge clk);
        n_vec++; if (a_timeout !== 1'b0) begin n_err++; $display("FAIL to_one_cycle: got %b expected 0", a_timeout); end
    endtask

    task automatic test_saturate;
        logic ok;
        logic found;
        do_reset;
        launch_b(ok);
        b_echo = 1'b1;
        repeat (58 * 20) @(negedge clk);
        b_echo = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b_valid) begin found = 1'b1; break; end
        end
        n_vec++; if (!ok || !found) begin n_err++; $display("FAIL sat_valid: got %b expected 1", found); end
        n_vec++; if (b_dist !== 4'd15)   begin n_err++; $display("FAIL sat_dist: got %0d expected 15", b_dist); end
        n_vec++; if (b_timeout !== 1'b0) begin n_err++; $display("FAIL sat_no_timeout: got %b expected 0", b_timeout); end
    endtask

    task automatic test_stale_echo;
        logic ok;
        logic vseen;
        logic found;
        do_reset;
        a_echo = 1'b1;
        repeat (5) @(negedge clk);
        launch_a(ok);
        vseen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (a_valid || a_timeout) vseen = 1'b1;
        end
        a_echo = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (a_valid || a_timeout) vseen = 1'b1;
        end
        n_vec++; if (!ok || vseen) begin n_err++; $display("FAIL stale_echo_ignored: pulse seen %b expected 0", vseen); end
        n_vec++; if (a_busy !== 1'b1) begin n_err++; $display("FAIL stale_still_busy: got %b expected 1", a_busy); end
        a_echo = 1'b1;
        repeat (116) @(negedge clk);
        a_echo = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_valid) begin found = 1'b1; break; end
        end
        n_vec++; if (!found || a_dist !== 9'd2) begin n_err++; $display("FAIL stale_then_real: got found=%b dist=%0d expected dist=2", found, a_dist); end
    endtask

    task automatic test_reset_mid;
        logic ok;
        logic found;
        logic pseen;
        do_reset;
        launch_a(ok);
        a_echo = 1'b1;
        repeat (116) @(negedge clk);
        a_echo = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_valid) begin found = 1'b1; break; end
        end
        n_vec++; if (!ok || !found || a_dist !== 9'd2) begin n_err++; $display("FAIL rm_first_dist: got found=%b dist=%0d expected dist=2", found, a_dist); end
        // Start a second measurement (auto build re-triggers on its own).
        @(negedge clk);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (a_trigger) begin found = 1'b1; break; end
            @(negedge clk);
        end
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (!a_trigger) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        n_vec++; if (!found || !ok) begin n_err++; $display("FAIL rm_second_trigger: got rise=%b fall=%b expected 11", found, ok); end
        a_echo = 1'b1;
        repeat (100) @(negedge clk);
        // Asynchronous reset mid-MEASURE, checked before the next clock edge
        #2 reset = 1'b1;
        #1;
        n_vec++; if ({a_trigger, a_busy, a_valid, a_timeout} !== 4'b0000)
            begin n_err++; $display("FAIL rm_async_flags: got %b expected 0000", {a_trigger, a_busy, a_valid, a_timeout}); end
        n_vec++; if (a_dist !== 9'd0) begin n_err++; $display("FAIL rm_async_dist: got %0d expected 0", a_dist); end
        pseen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (a_valid || a_timeout || a_busy) pseen = 1'b1;
        end
        reset = 1'b0;
        a_echo = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (a_valid || a_timeout || a_busy) pseen = 1'b1;
        end
        n_vec++; if (pseen !== 1'b0) begin n_err++; $display("FAIL rm_no_pulse: got %b expected 0", pseen); end
        launch_a(ok);
        a_echo = 1'b1;
        repeat (116) @(negedge clk);
        a_echo = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_valid) begin found = 1'b1; break; end
        end
        n_vec++; if (!ok || !found || a_dist !== 9'd2) begin n_err++; $display("FAIL rm_after_release: got found=%b dist=%0d expected dist=2", found, a_dist); end
        // Asynchronous reset mid-TRIG: trigger must drop before the next edge
        do_reset;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (a_trigger !== 1'b1) begin n_err++; $display("FAIL rt_trigger_high: got %b expected 1", a_trigger); end
        #2 reset = 1'b1;
        #1;
        n_vec++; if ({a_trigger, a_busy} !== 2'b00) begin n_err++; $display("FAIL rt_trigger_drop: got %b expected 00", {a_trigger, a_busy}); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

`ifdef ULTRASONIDO_AUTO_EN
    task automatic test_auto;
        logic ok;
        logic found;
        logic bdrop;
        int   n;
        do_reset;
        launch_a(ok);
        a_echo = 1'b1;
        repeat (116) @(negedge clk);
        a_echo = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_valid) begin found = 1'b1; break; end
        end
        n = 0; bdrop = 1'b0; ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            n++;
            if (!a_busy) bdrop = 1'b1;
            if (a_trigger) begin ok = 1'b1; break; end
        end
        // DONE cycle, then 100 HOLD cycles, then trigger
        n_vec++; if (!found || !ok || n !== 101) begin n_err++; $display("FAIL auto_retrigger: got found=%b cycles=%0d expected 101", found, n); end
        n_vec++; if (bdrop !== 1'b0) begin n_err++; $display("FAIL auto_busy_hold: got drop=%b expected 0", bdrop); end
    endtask
`else
    task automatic test_no_retrigger;
        logic ok;
        logic found;
        logic seen;
        do_reset;
        launch_a(ok);
        a_echo = 1'b1;
        repeat (50) @(negedge clk);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        repeat (65) @(negedge clk);
        a_echo = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_valid) begin found = 1'b1; break; end
        end
        n_vec++; if (!ok || !found || a_dist !== 9'd2) begin n_err++; $display("FAIL nr_dist: got found=%b dist=%0d expected dist=2", found, a_dist); end
        seen = 1'b0;
        repeat (150) begin
            @(negedge clk);
            if (a_trigger || a_busy) seen = 1'b1;
        end
        n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL nr_stays_idle: got %b expected 0", seen); end
    endtask
`endif

    initial begin
        test_reset;
        test_trigger;
        test_measure_10;
        test_cm_boundary;
        test_timeout;
        test_saturate;
        test_stale_echo;
        test_reset_mid;
`ifdef ULTRASONIDO_AUTO_EN
        test_auto;
`else
        test_no_retrigger;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
